uart_bus_loader: RTL and testbench
==================================

UART_BUS_LOADER -- requirements
Module: uart_bus_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000: max idle cycles between bytes of a multi-byte command.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_rx_dat  input  8  received UART byte, valid only with i_rx_valid.
REQ-005 SHALL have port i_rx_valid  input  1  one-cycle strobe per received byte.
REQ-006 SHALL have port o_tx_dat  output  8  byte to transmit.
REQ-007 SHALL have port o_tx_valid  output  1  transmit request, held until accepted.
REQ-008 SHALL have port i_tx_ready  input  1  transmitter accepts o_tx_dat when high with o_tx_valid.
REQ-009 SHALL have port o_wb_addr  output  16  bus word address.
REQ-010 SHALL have port o_wb_dat  output  16  bus write data.
REQ-011 SHALL have port i_wb_dat  input  16  bus read data, valid the cycle after a read cycle.
REQ-012 SHALL have port o_wb_we  output  1  bus write enable.
REQ-013 SHALL have port o_wb_cyc  output  1  bus cycle strobe, single-cycle transfers.
REQ-014 SHALL have port o_cpu_hold  output  1  holds d16 CPU in reset while high.

Function
REQ-015 SHALL decode in IDLE: 0x41 'A' -> ADDR_HI; 0x57 'W' -> DATA_HI; 0x52 'R' -> READ; 0x47 'G' -> o_cpu_hold=0; 0x48 'H' -> o_cpu_hold=1; any other byte ignored, no response.
REQ-016 SHALL, for 'A', take next two bytes (hi, lo) into the 16-bit address register; return to IDLE; no bus access.
REQ-017 SHALL, for 'W', take next two bytes (hi, lo) as data word; the cycle after lo arrives, assert o_wb_cyc=1, o_wb_we=1 for exactly one cycle with current address/data; then address +1, return to IDLE.
REQ-018 SHALL, for 'R', assert o_wb_cyc=1, o_wb_we=0 for exactly one cycle on the cycle after 'R'; capture i_wb_dat on the following cycle.
REQ-019 SHALL then send captured hi byte (TX_HI), then lo byte (TX_LO); each byte held on o_tx_dat with o_tx_valid=1 until a cycle with i_tx_ready=1; then address +1, IDLE.
REQ-020 SHALL use states IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WRITE, READ, READ_WAIT, TX_HI, TX_LO.
REQ-021 SHALL drop i_rx_valid bytes received in WRITE, READ, READ_WAIT, TX_HI, TX_LO.
REQ-022 SHALL wrap address 0xFFFF -> 0x0000 on increment.
REQ-023 SHALL run an idle counter in ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, cleared on entry and on every accepted byte; on reaching TIMEOUT return to IDLE with no bus access and address unchanged.
REQ-024 SHALL give priority to a byte arriving in the same cycle the counter reaches TIMEOUT (byte accepted).
REQ-025 SHALL keep o_wb_cyc and o_wb_we low outside WRITE/READ; o_wb_addr continuously drives the address register.
REQ-026 SHALL keep o_tx_valid low outside TX_HI/TX_LO.
REQ-027 SHALL change o_cpu_hold only from IDLE via 'G'/'H'; bus and hold are independent (loading while CPU runs permitted).

Reset
REQ-028 SHALL on i_reset low asynchronously force: state IDLE, address 0x0000, data 0x0000, o_wb_cyc=0, o_wb_we=0, o_wb_dat=0, o_tx_valid=0, o_tx_dat=0x00, idle counter 0, o_cpu_hold=1.
REQ-029 SHALL abort any command or pending transmit on reset mid-operation with no further bus cycle.
REQ-030 SHALL resume operation on the first rising edge after i_reset returns high.

Verification
REQ-031 SHALL cover: bytes 41 12 34, 57 AB CD -> one write cycle addr 0x1234 data 0xABCD, we=1; address then 0x1235.
REQ-032 SHALL cover: memory[0x1234]=0xBEEF, bytes 41 12 34, 52, i_tx_ready low 5 cycles -> one read cycle addr 0x1234; o_tx_dat 0xBE held 5 cycles, then 0xEF; address 0x1235.
REQ-033 SHALL cover: bytes 41 FF FF, 57 00 01, 57 00 02 -> writes 0x0001@0xFFFF, 0x0002@0x0000.
REQ-034 SHALL cover: TIMEOUT=8, bytes 57 AA then 9 idle cycles, then 55 -> no bus cycle; 0x55 ignored in IDLE.
REQ-035 SHALL cover: after reset o_cpu_hold=1; byte 47 -> 0; byte 48 -> 1; reset asserted during TX_HI -> o_tx_valid=0 next sample, hold=1.

Source files
------------

// File: rtl/uart_bus_loader_if.sv
// Bundles the UART byte streams, the single-cycle word bus and the CPU hold
// line that connect the serial loader to the rest of the system.
// The master side is the loader itself; the slave side is the environment
// (UART receiver/transmitter, memory bus and the d16 CPU).
interface uart_bus_loader_if;
    logic [7:0]  i_rx_dat;
    logic        i_rx_valid;
    logic [7:0]  o_tx_dat;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [15:0] o_wb_addr;
    logic [15:0] o_wb_dat;
    logic [15:0] i_wb_dat;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_cpu_hold;

    modport master (
        input  i_rx_dat,
        input  i_rx_valid,
        output o_tx_dat,
        output o_tx_valid,
        input  i_tx_ready,
        output o_wb_addr,
        output o_wb_dat,
        input  i_wb_dat,
        output o_wb_we,
        output o_wb_cyc,
        output o_cpu_hold
    );

    modport slave (
        output i_rx_dat,
        output i_rx_valid,
        input  o_tx_dat,
        input  o_tx_valid,
        output i_tx_ready,
        input  o_wb_addr,
        input  o_wb_dat,
        output i_wb_dat,
        input  o_wb_we,
        input  o_wb_cyc,
        input  o_cpu_hold
    );
endinterface

// File: rtl/uart_bus_loader.sv
// Serial command loader: turns single-letter UART commands into word bus
// accesses so a host can load and inspect memory and start/stop the d16 CPU.
//   'A' hi lo : set the bus address
//   'W' hi lo : write a word at the address, then advance the address
//   'R'       : read a word, send it back hi byte first, then advance
//   'G' / 'H' : release / hold the CPU
// Multi-byte commands are abandoned if the host goes quiet for longer than
// TIMEOUT cycles, so a lost byte cannot wedge the loader.
module uart_bus_loader #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    uart_bus_loader_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        READ,
        READ_WAIT,
        TX_HI,
        TX_LO
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] addr;
    logic [15:0] addr_next;
    logic [15:0] data;
    logic [15:0] data_next;
    logic [15:0] rd_data;
    logic [15:0] rd_data_next;
    logic [7:0]  hi_byte;
    logic [7:0]  hi_byte_next;
    logic [15:0] idle_cnt;
    logic [15:0] idle_cnt_next;
    logic        cpu_hold;
    logic        cpu_hold_next;

    // The high byte is parked in hi_byte so a timed-out command leaves both
    // the address and data registers untouched.
    // State and datapath registers; reset holds the CPU and clears everything else.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            addr     <= 16'h0000;
            data     <= 16'h0000;
            rd_data  <= 16'h0000;
            hi_byte  <= 8'h00;
            idle_cnt <= 16'h0000;
            cpu_hold <= 1'b1;
        end else begin
            state    <= state_next;
            addr     <= addr_next;
            data     <= data_next;
            rd_data  <= rd_data_next;
            hi_byte  <= hi_byte_next;
            idle_cnt <= idle_cnt_next;
            cpu_hold <= cpu_hold_next;
        end
    end

    // Idle counter defaults to zero, which clears it on entry to and on every
    // byte accepted in the operand states; a byte wins over the timeout.
    // Command decoding and sequencing of bus and transmit phases.
    always_comb begin
        state_next    = state;
        addr_next     = addr;
        data_next     = data;
        rd_data_next  = rd_data;
        hi_byte_next  = hi_byte;
        idle_cnt_next = 16'h0000;
        cpu_hold_next = cpu_hold;

        case (state)
            IDLE: begin
                if (bus.i_rx_valid) begin
                    case (bus.i_rx_dat)
                        8'h41:   state_next = ADDR_HI;
                        8'h57:   state_next = DATA_HI;
                        8'h52:   state_next = READ;
                        8'h47:   cpu_hold_next = 1'b0;
                        8'h48:   cpu_hold_next = 1'b1;
                        default: state_next = IDLE;
                    endcase
                end
            end

            ADDR_HI: begin
                if (bus.i_rx_valid) begin
                    hi_byte_next = bus.i_rx_dat;
                    state_next   = ADDR_LO;
                end else if (idle_cnt == TIMEOUT) begin
                    state_next = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt + 16'd1;
                end
            end

            ADDR_LO: begin
                if (bus.i_rx_valid) begin
                    addr_next  = {hi_byte, bus.i_rx_dat};
                    state_next = IDLE;
                end else if (idle_cnt == TIMEOUT) begin
                    state_next = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt + 16'd1;
                end
            end

            DATA_HI: begin
                if (bus.i_rx_valid) begin
                    hi_byte_next = bus.i_rx_dat;
                    state_next   = DATA_LO;
                end else if (idle_cnt == TIMEOUT) begin
                    state_next = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt + 16'd1;
                end
            end

            DATA_LO: begin
                if (bus.i_rx_valid) begin
                    data_next  = {hi_byte, bus.i_rx_dat};
                    state_next = WRITE;
                end else if (idle_cnt == TIMEOUT) begin
                    state_next = IDLE;
                end else begin
                    idle_cnt_next = idle_cnt + 16'd1;
                end
            end

            WRITE: begin
                addr_next  = addr + 16'd1;
                state_next = IDLE;
            end

            READ: begin
                state_next = READ_WAIT;
            end

            READ_WAIT: begin
                rd_data_next = bus.i_wb_dat;
                state_next   = TX_HI;
            end

            TX_HI: begin
                if (bus.i_tx_ready) begin
                    state_next = TX_LO;
                end
            end

            TX_LO: begin
                if (bus.i_tx_ready) begin
                    addr_next  = addr + 16'd1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.o_wb_addr  = addr;
    assign bus.o_wb_dat   = data;
    assign bus.o_wb_cyc   = (state == WRITE) || (state == READ);
    assign bus.o_wb_we    = (state == WRITE);
    assign bus.o_tx_valid = (state == TX_HI) || (state == TX_LO);
    assign bus.o_cpu_hold = cpu_hold;

    // Transmit byte is a pure function of state so reset clears it immediately.
    always_comb begin
        bus.o_tx_dat = 8'h00;
        if (state == TX_HI) begin
            bus.o_tx_dat = rd_data[15:8];
        end else if (state == TX_LO) begin
            bus.o_tx_dat = rd_data[7:0];
        end
    end

endmodule

// File: tb/tb_uart_bus_loader.sv
// Directed bench for the serial bus loader: a small word memory answers the
// bus, and every expected value below is worked out by hand from the
// command bytes sent.
module tb_uart_bus_loader;

    logic i_clk = 1'b0;
    logic i_reset;

    uart_bus_loader_if bus ();

    uart_bus_loader #(
        .TIMEOUT(16'd8)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int          check_count = 0;
    int          error_count = 0;
    logic [15:0] mem [0:65535];
    int          wr_count = 0;
    int          rd_count = 0;
    logic [15:0] last_addr = 16'h0000;
    logic [15:0] last_data = 16'h0000;

    // Memory model: stores writes, returns read data the cycle after a read.
    always @(posedge i_clk) begin
        if (bus.o_wb_cyc) begin
            last_addr <= bus.o_wb_addr;
            if (bus.o_wb_we) begin
                mem[bus.o_wb_addr] <= bus.o_wb_dat;
                last_data          <= bus.o_wb_dat;
                wr_count           <= wr_count + 1;
            end else begin
                bus.i_wb_dat <= mem[bus.o_wb_addr];
                rd_count     <= rd_count + 1;
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Presents one received byte for exactly one clock.
    task automatic applyStimulus(input logic [7:0] b);
        bus.i_rx_dat   = b;
        bus.i_rx_valid = 1'b1;
        tick();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_dat   = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) else begin
            error_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering write, read with backpressure, wrap, timeouts, hold and reset.
    initial begin
        i_reset        = 1'b0;
        bus.i_rx_dat   = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b0;
        repeat (2) tick();

        $display("[TB] reset values");
        checkOutput("rst_hold",     32'(bus.o_cpu_hold), 32'h1);
        checkOutput("rst_addr",     32'(bus.o_wb_addr),  32'h0000);
        checkOutput("rst_wdat",     32'(bus.o_wb_dat),   32'h0000);
        checkOutput("rst_cyc",      32'(bus.o_wb_cyc),   32'h0);
        checkOutput("rst_we",       32'(bus.o_wb_we),    32'h0);
        checkOutput("rst_tx_valid", 32'(bus.o_tx_valid), 32'h0);
        checkOutput("rst_tx_dat",   32'(bus.o_tx_dat),   32'h00);
        i_reset = 1'b1;
        tick();

        $display("[TB] address set and single write");
        applyStimulus(8'h41); applyStimulus(8'h12); applyStimulus(8'h34);
        checkOutput("a_addr", 32'(bus.o_wb_addr), 32'h1234);
        checkOutput("a_cyc",  32'(bus.o_wb_cyc),  32'h0);
        applyStimulus(8'h57); applyStimulus(8'hAB); applyStimulus(8'hCD);
        checkOutput("w_cyc",  32'(bus.o_wb_cyc),  32'h1);
        checkOutput("w_we",   32'(bus.o_wb_we),   32'h1);
        checkOutput("w_addr", 32'(bus.o_wb_addr), 32'h1234);
        checkOutput("w_dat",  32'(bus.o_wb_dat),  32'hABCD);
        tick();
        checkOutput("w_cyc_after", 32'(bus.o_wb_cyc), 32'h0);
        checkOutput("w_addr_inc",  32'(bus.o_wb_addr), 32'h1235);
        checkOutput("w_count",     32'(wr_count),      32'd1);
        checkOutput("w_bus_addr",  32'(last_addr),     32'h1234);
        checkOutput("w_bus_data",  32'(last_data),     32'hABCD);

        $display("[TB] read with transmit backpressure");
        applyStimulus(8'h41); applyStimulus(8'h12); applyStimulus(8'h34);
        applyStimulus(8'h57); applyStimulus(8'hBE); applyStimulus(8'hEF);
        tick();
        checkOutput("pre_count", 32'(wr_count), 32'd2);
        applyStimulus(8'h41); applyStimulus(8'h12); applyStimulus(8'h34);
        bus.i_tx_ready = 1'b0;
        applyStimulus(8'h52);
        checkOutput("r_cyc",  32'(bus.o_wb_cyc),  32'h1);
        checkOutput("r_we",   32'(bus.o_wb_we),   32'h0);
        checkOutput("r_addr", 32'(bus.o_wb_addr), 32'h1234);
        tick();
        checkOutput("r_wait_cyc", 32'(bus.o_wb_cyc),   32'h0);
        checkOutput("r_wait_txv", 32'(bus.o_tx_valid), 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("txhi_valid", 32'(bus.o_tx_valid), 32'h1);
            checkOutput("txhi_dat",   32'(bus.o_tx_dat),   32'hBE);
            if (i == 2) applyStimulus(8'h47);
            else        tick();
        end
        checkOutput("txhi_held", 32'(bus.o_tx_dat), 32'hBE);
        bus.i_tx_ready = 1'b1;
        tick();
        checkOutput("txlo_valid", 32'(bus.o_tx_valid), 32'h1);
        checkOutput("txlo_dat",   32'(bus.o_tx_dat),   32'hEF);
        tick();
        bus.i_tx_ready = 1'b0;
        checkOutput("tx_done_valid", 32'(bus.o_tx_valid), 32'h0);
        checkOutput("tx_done_dat",   32'(bus.o_tx_dat),   32'h00);
        checkOutput("r_addr_inc",    32'(bus.o_wb_addr),  32'h1235);
        checkOutput("r_count",       32'(rd_count),       32'd1);
        checkOutput("r_bus_addr",    32'(last_addr),      32'h1234);
        checkOutput("r_drop_hold",   32'(bus.o_cpu_hold), 32'h1);

        $display("[TB] address wrap");
        applyStimulus(8'h41); applyStimulus(8'hFF); applyStimulus(8'hFF);
        applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h01);
        tick();
        checkOutput("wrap1_addr", 32'(last_addr),     32'hFFFF);
        checkOutput("wrap1_data", 32'(last_data),     32'h0001);
        checkOutput("wrap1_next", 32'(bus.o_wb_addr), 32'h0000);
        applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h02);
        tick();
        checkOutput("wrap2_addr",  32'(last_addr),     32'h0000);
        checkOutput("wrap2_data",  32'(last_data),     32'h0002);
        checkOutput("wrap2_next",  32'(bus.o_wb_addr), 32'h0001);
        checkOutput("wrap_count",  32'(wr_count),      32'd4);
        checkOutput("wrap_mem_ff", 32'(mem[16'hFFFF]), 32'h0001);

        $display("[TB] operand timeout");
        applyStimulus(8'h57); applyStimulus(8'hAA);
        repeat (9) tick();
        applyStimulus(8'h55);
        repeat (2) tick();
        checkOutput("to_count", 32'(wr_count),      32'd4);
        checkOutput("to_cyc",   32'(bus.o_wb_cyc),  32'h0);
        checkOutput("to_addr",  32'(bus.o_wb_addr), 32'h0001);
        checkOutput("to_wdat",  32'(bus.o_wb_dat),  32'h0002);
        applyStimulus(8'h57); applyStimulus(8'hAA);
        repeat (8) tick();
        applyStimulus(8'h55);
        checkOutput("edge_cyc",  32'(bus.o_wb_cyc),  32'h1);
        checkOutput("edge_wdat", 32'(bus.o_wb_dat),  32'hAA55);
        checkOutput("edge_addr", 32'(bus.o_wb_addr), 32'h0001);
        tick();
        checkOutput("edge_count", 32'(wr_count),      32'd5);
        checkOutput("edge_next",  32'(bus.o_wb_addr), 32'h0002);
        applyStimulus(8'h41); applyStimulus(8'h12);
        repeat (9) tick();
        applyStimulus(8'h34);
        tick();
        checkOutput("to_a_addr", 32'(bus.o_wb_addr), 32'h0002);

        $display("[TB] cpu hold and reset during transmit");
        checkOutput("hold_init", 32'(bus.o_cpu_hold), 32'h1);
        applyStimulus(8'h47);
        checkOutput("hold_go",   32'(bus.o_cpu_hold), 32'h0);
        applyStimulus(8'h48);
        checkOutput("hold_halt", 32'(bus.o_cpu_hold), 32'h1);
        applyStimulus(8'h47);
        checkOutput("hold_go2",  32'(bus.o_cpu_hold), 32'h0);
        bus.i_tx_ready = 1'b0;
        applyStimulus(8'h52);
        tick();
        tick();
        checkOutput("pre_rst_txv", 32'(bus.o_tx_valid), 32'h1);
        checkOutput("pre_rst_rd",  32'(rd_count),       32'd2);
        i_reset = 1'b0;
        #1;
        checkOutput("mid_rst_txv",  32'(bus.o_tx_valid), 32'h0);
        checkOutput("mid_rst_txd",  32'(bus.o_tx_dat),   32'h00);
        checkOutput("mid_rst_hold", 32'(bus.o_cpu_hold), 32'h1);
        checkOutput("mid_rst_addr", 32'(bus.o_wb_addr),  32'h0000);
        tick();
        i_reset = 1'b1;
        tick();
        checkOutput("post_rst_txv", 32'(bus.o_tx_valid), 32'h0);
        checkOutput("post_rst_cyc", 32'(bus.o_wb_cyc),   32'h0);
        checkOutput("post_rst_rd",  32'(rd_count),       32'd2);
        applyStimulus(8'h41); applyStimulus(8'h00); applyStimulus(8'h05);
        checkOutput("resume_addr", 32'(bus.o_wb_addr), 32'h0005);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
